// File: rtl/lock_pkg.sv
// Shared constants and helpers for the password-lock input front end.
// Button indices, event-flag bit positions and priority/popcount helpers.
package lock_pkg;

    localparam int SW_NUM  = 10;
    localparam int BTN_NUM = 4;

    localparam int BTN_RESET     = 0;
    localparam int BTN_ADMIN     = 1;
    localparam int BTN_OK        = 2;
    localparam int BTN_BACKSPACE = 3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int FLAG_STROBE = 0;
    localparam int FLAG_DIR    = 1;

    typedef logic [3:0] sw_idx_t;
    typedef logic [1:0] btn_idx_t;

    // Lowest set index wins; result is don't-care when the vector is zero.
    function automatic sw_idx_t lowest_sw(input logic [SW_NUM-1:0] v);
        lowest_sw = '0;
        for (int i = SW_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_sw = sw_idx_t'(i);
        end
    endfunction

    function automatic btn_idx_t lowest_btn(input logic [BTN_NUM-1:0] v);
        lowest_btn = '0;
        for (int i = BTN_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_btn = btn_idx_t'(i);
        end
    endfunction

    function automatic logic [3:0] popcount_sw(input logic [SW_NUM-1:0] v);
        popcount_sw = '0;
        for (int i = 0; i < SW_NUM; i++) begin
            popcount_sw = popcount_sw + {3'b000, v[i]};
        end
    endfunction

endpackage

// File: rtl/lock_input_conditioner_if.sv
// Raw pins in, conditioned switch/button events out.
// Events are single-cycle strobes with no backpressure: the consumer must take
// index/direction in the cycle the strobe is high; indices hold otherwise.
interface lock_input_conditioner_if;
    import lock_pkg::*;

    logic [SW_NUM-1:0]  SW;
    logic [BTN_NUM-1:0] BTN;
    logic [SW_NUM-1:0]  SW_Level;
    logic [1:0]         SW_Change_Flag;
    logic [3:0]         Which_SW_Change;
    logic               BTN_Change_Flag;
    logic [1:0]         Which_BTN_Posedge;
    logic [7:0]         Up_Queue;

    modport master (
        output SW, BTN,
        input  SW_Level, SW_Change_Flag, Which_SW_Change,
        input  BTN_Change_Flag, Which_BTN_Posedge, Up_Queue
    );

    modport slave (
        input  SW, BTN,
        output SW_Level, SW_Change_Flag, Which_SW_Change,
        output BTN_Change_Flag, Which_BTN_Posedge, Up_Queue
    );

endinterface

// File: rtl/lock_debounce.sv
// One input bit: 2-flop synchroniser, stability counter and accepted level.
// flip is combinational and high on the edge that toggles stable.
module lock_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic stable,
    output logic flip
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differ;

    assign differ = (s2 != stable);
    // The counter would reach DEBOUNCE_CYCLES on this edge: accept instead.
    assign flip   = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (!differ || flip) cnt <= '0;
            else                 cnt <= cnt + CNT_W'(1);
            if (flip) stable <= ~stable;
        end
    end

endmodule

// File: rtl/lock_input_conditioner.sv
// Debounces 10 switches and 4 buttons and serialises their activity into
// one-at-a-time events. Optional Up_Queue tracker: LOCK_INPUT_UP_QUEUE_EN.
module lock_input_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RESET,
    lock_input_conditioner_if.slave bus
);

    logic [SW_NUM-1:0]  stable_sw, flip_sw, p_sw, p_sw_next;
    logic [BTN_NUM-1:0] stable_btn, flip_btn, p_btn, p_btn_next;
    sw_idx_t            sw_sel, which_sw_q;
    btn_idx_t           btn_sel, which_btn_q;
    logic               sw_any, btn_any;
    logic               sw_strobe_q, sw_dir_q, btn_strobe_q;

    for (genvar i = 0; i < SW_NUM; i++) begin : g_sw
        lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .CLK(CLK), .RESET(RESET), .raw(bus.SW[i]),
            .stable(stable_sw[i]), .flip(flip_sw[i])
        );
    end

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
        lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .CLK(CLK), .RESET(RESET), .raw(bus.BTN[i]),
            .stable(stable_btn[i]), .flip(flip_btn[i])
        );
    end

    assign sw_any  = |p_sw;
    assign btn_any = |p_btn;

    // Clear the emitted bit first, then fold in this edge's flips, so a flip
    // landing on the emission edge keeps the bit pending.
    always_comb begin
        sw_sel     = lowest_sw(p_sw);
        btn_sel    = lowest_btn(p_btn);
        p_sw_next  = p_sw;
        p_btn_next = p_btn;
        if (sw_any)  p_sw_next[sw_sel]   = 1'b0;
        if (btn_any) p_btn_next[btn_sel] = 1'b0;
        p_sw_next  = p_sw_next ^ flip_sw;
        p_btn_next = p_btn_next | (flip_btn & ~stable_btn);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            p_sw         <= '0;
            p_btn        <= '0;
            sw_strobe_q  <= 1'b0;
            sw_dir_q     <= 1'b0;
            which_sw_q   <= '0;
            btn_strobe_q <= 1'b0;
            which_btn_q  <= '0;
        end else begin
            p_sw         <= p_sw_next;
            p_btn        <= p_btn_next;
            sw_strobe_q  <= sw_any;
            btn_strobe_q <= btn_any;
            if (sw_any) begin
                sw_dir_q   <= stable_sw[sw_sel];
                which_sw_q <= sw_sel;
            end
            if (btn_any) which_btn_q <= btn_sel;
        end
    end

    assign bus.SW_Level                    = stable_sw;
    assign bus.SW_Change_Flag[FLAG_STROBE] = sw_strobe_q;
    assign bus.SW_Change_Flag[FLAG_DIR]    = sw_dir_q;
    assign bus.Which_SW_Change             = which_sw_q;
    assign bus.BTN_Change_Flag             = btn_strobe_q;
    assign bus.Which_BTN_Posedge           = which_btn_q;

`ifdef LOCK_INPUT_UP_QUEUE_EN
    logic [3:0] up_idx_q;
    logic [3:0] up_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            up_idx_q <= '0;
            up_cnt_q <= '0;
        end else begin
            if (sw_any && (stable_sw[sw_sel] == DIR_UP)) up_idx_q <= sw_sel;
            up_cnt_q <= popcount_sw(stable_sw);
        end
    end

    assign bus.Up_Queue = {up_idx_q, up_cnt_q};
`else
    assign bus.Up_Queue = 8'h00;
`endif

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Bench for lock_input_conditioner with DEBOUNCE_CYCLES = 4: directed scenarios
// plus random pin activity checked cycle by cycle against a window-based model.
module tb_lock_input_conditioner;

    localparam int D = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    lock_input_conditioner_if bus_if ();

    lock_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK(clk),
        .RESET(reset),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a level is accepted once the last D synchronised samples all
    // disagree with the current accepted level; pending events drain lowest first.
    logic [13:0] hist [0:D];
    logic [9:0]  m_stable_sw, m_p_sw;
    logic [3:0]  m_stable_btn, m_p_btn;
    logic [1:0]  m_sw_flag;
    logic [3:0]  m_which_sw;
    logic        m_btn_flag;
    logic [1:0]  m_which_btn;
    logic [3:0]  m_uq_idx, m_uq_cnt;

    always @(posedge clk) begin : model
        logic [13:0] st;
        logic [13:0] fl;
        int          nd;
        if (reset) begin
            for (int j = 0; j <= D; j++) hist[j] = '0;
            m_stable_sw = '0; m_p_sw = '0; m_stable_btn = '0; m_p_btn = '0;
            m_sw_flag = '0; m_which_sw = '0; m_btn_flag = 1'b0; m_which_btn = '0;
            m_uq_idx = '0; m_uq_cnt = '0;
        end else begin
            st = {m_stable_btn, m_stable_sw};
            fl = '0;
            for (int b = 0; b < 14; b++) begin
                nd = 0;
                for (int j = 1; j <= D; j++) if (hist[j][b] != st[b]) nd++;
                if (nd == D) fl[b] = 1'b1;
            end
            m_sw_flag[0] = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (m_p_sw[i]) begin
                    m_sw_flag  = {m_stable_sw[i], 1'b1};
                    m_which_sw = 4'(i);
                    if (m_stable_sw[i]) m_uq_idx = 4'(i);
                    m_p_sw[i]  = 1'b0;
                    break;
                end
            end
            m_btn_flag = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_p_btn[i]) begin
                    m_btn_flag  = 1'b1;
                    m_which_btn = 2'(i);
                    m_p_btn[i]  = 1'b0;
                    break;
                end
            end
            m_uq_cnt = 4'($countones(m_stable_sw));
            m_p_sw   = m_p_sw ^ fl[9:0];
            m_p_btn  = m_p_btn | (fl[13:10] & ~m_stable_btn);
            m_stable_sw  = m_stable_sw ^ fl[9:0];
            m_stable_btn = m_stable_btn ^ fl[13:10];
            for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = {bus_if.BTN, bus_if.SW};
        end
    end

    function automatic logic [26:0] obs_word();
        return {bus_if.SW_Level, bus_if.SW_Change_Flag, bus_if.Which_SW_Change,
                bus_if.BTN_Change_Flag, bus_if.Which_BTN_Posedge, bus_if.Up_Queue};
    endfunction

    function automatic logic [26:0] exp_word();
        logic [7:0] uq;
`ifdef LOCK_INPUT_UP_QUEUE_EN
        uq = {m_uq_idx, m_uq_cnt};
`else
        uq = 8'h00;
`endif
        return {m_stable_sw, m_sw_flag, m_which_sw, m_btn_flag, m_which_btn, uq};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus_if.SW = '0;
        bus_if.BTN = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++;
        if (obs_word() !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs_word(), 27'd0);
        end
    endtask

    task automatic test_sw_up();
        int cyc_q[$];
        logic [4:0] seen_q[$];
        logic [4:0] exp_q[$];
        exp_q.push_back({1'b1, 4'd3});
        bus_if.SW[3] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (obs_word() !== exp_word()) begin
                bad++;
                $display("FAIL sw_up_model cyc=%0d got=%h exp=%h", c, obs_word(), exp_word());
            end
            if (bus_if.SW_Change_Flag[0]) begin
                cyc_q.push_back(c);
                seen_q.push_back({bus_if.SW_Change_Flag[1], bus_if.Which_SW_Change});
            end
        end
        total++;
        if (seen_q.size() != 1 || seen_q[0] !== exp_q[0] || cyc_q[0] != 6) begin
            bad++;
            $display("FAIL sw_up_event count=%0d first=%h at=%0d exp=%h at 6", seen_q.size(),
                     (seen_q.size() > 0) ? seen_q[0] : 5'h0, (cyc_q.size() > 0) ? cyc_q[0] : -1, exp_q[0]);
        end
        total++;
        if (bus_if.SW_Level[3] !== 1'b1) begin
            bad++;
            $display("FAIL sw_up_level got=%b exp=1", bus_if.SW_Level[3]);
        end
    endtask

    task automatic test_glitch();
        int n;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            bus_if.SW[5] = (c < 3);
            @(negedge clk);
            total++;
            if (obs_word() !== exp_word()) begin
                bad++;
                $display("FAIL glitch_model cyc=%0d got=%h exp=%h", c, obs_word(), exp_word());
            end
            if (bus_if.SW_Change_Flag[0]) n++;
        end
        total++;
        if (n != 0 || bus_if.SW_Level[5] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_event strobes=%0d level=%b exp 0 strobes level 0", n, bus_if.SW_Level[5]);
        end
    endtask

    task automatic test_simultaneous();
        int cyc_q[$];
        logic [4:0] seen_q[$];
        logic [4:0] exp_q[$];
        exp_q = '{{1'b1, 4'd2}, {1'b1, 4'd7}};
        bus_if.SW[7] = 1'b1;
        bus_if.SW[2] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (obs_word() !== exp_word()) begin
                bad++;
                $display("FAIL simul_model cyc=%0d got=%h exp=%h", c, obs_word(), exp_word());
            end
            if (bus_if.SW_Change_Flag[0]) begin
                cyc_q.push_back(c);
                seen_q.push_back({bus_if.SW_Change_Flag[1], bus_if.Which_SW_Change});
            end
        end
        total++;
        if (seen_q.size() != 2 || seen_q[0] !== exp_q[0] || seen_q[1] !== exp_q[1]
            || cyc_q[1] != cyc_q[0] + 1) begin
            bad++;
            $display("FAIL simul_order count=%0d got=%h,%h exp=%h,%h back-to-back", seen_q.size(),
                     (seen_q.size() > 0) ? seen_q[0] : 5'h0, (seen_q.size() > 1) ? seen_q[1] : 5'h0,
                     exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_buttons();
        int cyc_q[$];
        logic [1:0] seen_q[$];
        logic [1:0] exp_q[$];
        int n_rel;
        exp_q = '{2'd1, 2'd2};
        bus_if.BTN[2] = 1'b1;
        bus_if.BTN[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (obs_word() !== exp_word()) begin
                bad++;
                $display("FAIL btn_model cyc=%0d got=%h exp=%h", c, obs_word(), exp_word());
            end
            if (bus_if.BTN_Change_Flag) begin
                cyc_q.push_back(c);
                seen_q.push_back(bus_if.Which_BTN_Posedge);
            end
        end
        total++;
        if (seen_q.size() != 2 || seen_q[0] !== exp_q[0] || seen_q[1] !== exp_q[1]
            || cyc_q[1] != cyc_q[0] + 1) begin
            bad++;
            $display("FAIL btn_press count=%0d got=%0d,%0d exp=1,2 back-to-back", seen_q.size(),
                     (seen_q.size() > 0) ? seen_q[0] : 2'd0, (seen_q.size() > 1) ? seen_q[1] : 2'd0);
        end
        bus_if.BTN = '0;
        n_rel = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_if.BTN_Change_Flag) n_rel++;
        end
        total++;
        if (n_rel != 0) begin
            bad++;
            $display("FAIL btn_release strobes=%0d exp=0", n_rel);
        end
    endtask

    task automatic test_reset_pending();
        int n;
        bus_if.SW[0] = 1'b1;
        for (int c = 0; c < 6; c++) @(negedge clk);
        reset = 1'b1;
        bus_if.SW = '0;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (obs_word() !== 27'd0) begin
            bad++;
            $display("FAIL reset_pending_outputs got=%h exp=%h", obs_word(), 27'd0);
        end
        n = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus_if.SW_Change_Flag[0] || bus_if.BTN_Change_Flag || obs_word() !== 27'd0) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_pending_quiet nonzero_cycles=%0d exp=0", n);
        end
    endtask

    task automatic test_up_queue();
        logic [7:0] exp1, exp2;
`ifdef LOCK_INPUT_UP_QUEUE_EN
        exp1 = 8'h92;
        exp2 = 8'h91;
`else
        exp1 = 8'h00;
        exp2 = 8'h00;
`endif
        bus_if.SW[4] = 1'b1;
        repeat (12) @(negedge clk);
        bus_if.SW[9] = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (bus_if.Up_Queue !== exp1) begin
            bad++;
            $display("FAIL up_queue_rise got=%h exp=%h", bus_if.Up_Queue, exp1);
        end
        bus_if.SW[4] = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (bus_if.Up_Queue !== exp2) begin
            bad++;
            $display("FAIL up_queue_fall got=%h exp=%h", bus_if.Up_Queue, exp2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            total++;
            if (obs_word() !== exp_word()) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs_word(), exp_word());
            end
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) < 12) bus_if.SW[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 99) < 6)  bus_if.BTN[$urandom_range(0, 3)] ^= 1'b1;
        end
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_if.SW  = '0;
        bus_if.BTN = '0;
        test_reset();
        test_sw_up();
        test_glitch();
        test_simultaneous();
        test_buttons();
        test_reset_pending();
        test_up_queue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
